boruss_fetch: RTL and testbench

- Instruction fetch stage of the Boruss CPU.
- Sits directly upstream of decode and drives the address of the combinational 256x8 program ROM.
- Walks the 8-bit program counter, assembles 1- or 2-byte instructions, and presents them to decode over a valid/ready handshake.
- Accepts PC redirects from execute.

---
 rtl/boruss_pkg.sv | 20 ++
 rtl/boruss_fetch.sv | 115 +++++++++++
 tb/tb_boruss_fetch.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/boruss_pkg.sv
// Shared Boruss definitions: opcode constants, fetch states and the
// instruction length decoder reused by fetch and decode.
package boruss_pkg;

  localparam logic [7:0] OP_LOAD_IMM = 8'h01;
  localparam logic [7:0] OP_SHL      = 8'h60;
  localparam logic [7:0] OP_JMP      = 8'h80;
  localparam logic [2:0] JMP_CLASS   = 3'b100;

  typedef enum logic {
    OPCODE,
    OPERAND
  } fetch_state_e;

  // Two-byte instructions carry an immediate: LOAD_IMM and the jump class.
  function automatic logic is_two_byte(input logic [7:0] opcode);
    return (opcode == OP_LOAD_IMM) || (opcode[7:5] == JMP_CLASS);
  endfunction

endpackage

// File: rtl/boruss_fetch.sv
// Boruss instruction fetch: walks the PC over the program ROM, assembles 1/2-byte
// instructions for decode. Define BORUSS_FETCH_JMP_FOLD_EN to fold JMP in fetch.
module boruss_fetch
  import boruss_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] rom_address,
  input  logic [7:0] rom_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_opcode,
  output logic [7:0] instr_operand,
  output logic [7:0] instr_pc,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_addr
);

  fetch_state_e state_q, state_d;
  logic [7:0]   pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [7:0]   opcode_q, opcode_d;
  logic [7:0]   operand_q, operand_d;
  logic [7:0]   ipc_q, ipc_d;
  logic [7:0]   pend_op_q, pend_op_d;
  logic [7:0]   pend_pc_q, pend_pc_d;
  logic         advance;

  assign advance = !valid_q || instr_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    ipc_d     = ipc_q;
    pend_op_d = pend_op_q;
    pend_pc_d = pend_pc_q;

    if (redirect_valid) begin
      pc_d    = redirect_addr;
      state_d = OPCODE;
      valid_d = 1'b0;
    end else if (advance) begin
      // Any held instruction is consumed here; valid is re-set only if one completes.
      valid_d = 1'b0;
      pc_d    = pc_q + 8'd1;
      case (state_q)
        OPCODE: begin
          if (is_two_byte(rom_data)) begin
            pend_op_d = rom_data;
            pend_pc_d = pc_q;
            state_d   = OPERAND;
          end else begin
            opcode_d  = rom_data;
            operand_d = 8'h00;
            ipc_d     = pc_q;
            valid_d   = 1'b1;
          end
        end
        OPERAND: begin
          state_d = OPCODE;
`ifdef BORUSS_FETCH_JMP_FOLD_EN
          if (pend_op_q == OP_JMP) begin
            pc_d = rom_data;
          end else begin
            opcode_d  = pend_op_q;
            operand_d = rom_data;
            ipc_d     = pend_pc_q;
            valid_d   = 1'b1;
          end
`else
          opcode_d  = pend_op_q;
          operand_d = rom_data;
          ipc_d     = pend_pc_q;
          valid_d   = 1'b1;
`endif
        end
        default: state_d = OPCODE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= OPCODE;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      opcode_q  <= 8'h00;
      operand_q <= 8'h00;
      ipc_q     <= 8'h00;
      pend_op_q <= 8'h00;
      pend_pc_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      ipc_q     <= ipc_d;
      pend_op_q <= pend_op_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign rom_address   = pc_q;
  assign instr_valid   = valid_q;
  assign instr_opcode  = opcode_q;
  assign instr_operand = operand_q;
  assign instr_pc      = ipc_q;

endmodule

// File: tb/tb_boruss_fetch.sv
// Self-checking bench for boruss_fetch: directed scenarios plus randomized traffic
// against a behavioural fetch model. Honours BORUSS_FETCH_JMP_FOLD_EN.
module tb_boruss_fetch;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rom_address;
  logic [7:0] rom_data;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic [7:0] instr_pc;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_addr = 8'h00;

  logic [7:0] rom [256];
  int errors = 0;
  int checks = 0;

  // Behavioural model: byte cursor, half-assembled instruction and presented instruction.
  logic [7:0] m_pc = 8'h00;
  logic       m_have_op = 1'b0;
  logic [7:0] m_op_byte = 8'h00;
  logic [7:0] m_op_addr = 8'h00;
  logic       m_valid = 1'b0;
  logic [7:0] m_opcode = 8'h00;
  logic [7:0] m_operand = 8'h00;
  logic [7:0] m_ipc = 8'h00;
  logic       model_ok = 1'b0;

  assign rom_data = rom[rom_address];

  always #5 clk = ~clk;

  boruss_fetch #(.RESET_PC(8'h00)) dut (
    .clk           (clk),
    .reset         (reset),
    .rom_address   (rom_address),
    .rom_data      (rom_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_operand (instr_operand),
    .instr_pc      (instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr)
  );

  function automatic logic needs_immediate(input logic [7:0] b);
    return (b == 8'h01) || (b >= 8'h80 && b <= 8'h9F);
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rdy, input logic rv, input logic [7:0] ra);
    reset          = rst;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_addr  = ra;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model update: what the stage must hold after this edge, from the rules alone.
  always @(posedge clk) begin
    logic [7:0] b;
    if (reset) begin
      m_pc = 8'h00; m_have_op = 1'b0; m_op_byte = 8'h00; m_op_addr = 8'h00;
      m_valid = 1'b0; m_opcode = 8'h00; m_operand = 8'h00; m_ipc = 8'h00;
      model_ok = 1'b1;
    end else if (redirect_valid) begin
      m_pc = redirect_addr; m_have_op = 1'b0; m_valid = 1'b0;
    end else if (!m_valid || instr_ready) begin
      b = rom[m_pc];
      m_valid = 1'b0;
      if (!m_have_op) begin
        if (needs_immediate(b)) begin
          m_have_op = 1'b1; m_op_byte = b; m_op_addr = m_pc;
        end else begin
          m_valid = 1'b1; m_opcode = b; m_operand = 8'h00; m_ipc = m_pc;
        end
        m_pc = m_pc + 8'd1;
      end else begin
        m_have_op = 1'b0;
`ifdef BORUSS_FETCH_JMP_FOLD_EN
        if (m_op_byte == 8'h80) begin
          m_pc = b;
        end else begin
          m_valid = 1'b1; m_opcode = m_op_byte; m_operand = b; m_ipc = m_op_addr;
          m_pc = m_pc + 8'd1;
        end
`else
        m_valid = 1'b1; m_opcode = m_op_byte; m_operand = b; m_ipc = m_op_addr;
        m_pc = m_pc + 8'd1;
`endif
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (model_ok) begin
      checkOutput("cyc_rom_address", rom_address, m_pc);
      checkOutput("cyc_instr_valid", {7'b0, instr_valid}, {7'b0, m_valid});
      if (m_valid) begin
        checkOutput("cyc_opcode", instr_opcode, m_opcode);
        checkOutput("cyc_operand", instr_operand, m_operand);
        checkOutput("cyc_instr_pc", instr_pc, m_ipc);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h60;
    rom[0] = 8'h01; rom[1] = 8'h01; rom[2] = 8'h60; rom[3] = 8'h60;
    rom[9] = 8'h80; rom[10] = 8'h05;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick(); tick();
    checkOutput("rst_valid", {7'b0, instr_valid}, 8'h00);
    checkOutput("rst_rom_address", rom_address, 8'h00);
    checkOutput("rst_opcode", instr_opcode, 8'h00);
    checkOutput("rst_operand", instr_operand, 8'h00);
    checkOutput("rst_pc", instr_pc, 8'h00);

    // Program {01,01,60,60} streaming with ready high
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    checkOutput("c1_valid", {7'b0, instr_valid}, 8'h00);
    tick();
    checkOutput("c2_valid", {7'b0, instr_valid}, 8'h01);
    checkOutput("c2_opcode", instr_opcode, 8'h01);
    checkOutput("c2_operand", instr_operand, 8'h01);
    checkOutput("c2_pc", instr_pc, 8'h00);
    checkOutput("c2_model_opcode", m_opcode, 8'h01);
    tick();
    checkOutput("c3_opcode", instr_opcode, 8'h60);
    checkOutput("c3_operand", instr_operand, 8'h00);
    checkOutput("c3_pc", instr_pc, 8'h02);
    tick();
    checkOutput("c4_opcode", instr_opcode, 8'h60);
    checkOutput("c4_pc", instr_pc, 8'h03);

    // Backpressure: everything frozen for five cycles
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_valid", {7'b0, instr_valid}, 8'h01);
      checkOutput("bp_opcode", instr_opcode, 8'h60);
      checkOutput("bp_pc", instr_pc, 8'h03);
      checkOutput("bp_rom_address", rom_address, 8'h04);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    checkOutput("bp_release_pc", instr_pc, 8'h04);
    tick();
    checkOutput("bp_next_pc", instr_pc, 8'h05);

    // Redirect into the JMP at 09, then abort it from OPERAND
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h09);
    tick();
    checkOutput("rd1_valid", {7'b0, instr_valid}, 8'h00);
    checkOutput("rd1_rom_address", rom_address, 8'h09);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    checkOutput("rd_operand_addr", rom_address, 8'h0A);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    checkOutput("rd2_rom_address", rom_address, 8'h00);
    checkOutput("rd2_valid", {7'b0, instr_valid}, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    tick(); tick();
    checkOutput("rd_after_opcode", instr_opcode, 8'h01);
    checkOutput("rd_after_pc", instr_pc, 8'h00);

    // PC wrap: LOAD_IMM at FF takes its operand from 00
    rom[255] = 8'h01; rom[0] = 8'hAA; rom[1] = 8'h01;
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    tick(); tick();
    checkOutput("wrap_valid", {7'b0, instr_valid}, 8'h01);
    checkOutput("wrap_opcode", instr_opcode, 8'h01);
    checkOutput("wrap_operand", instr_operand, 8'hAA);
    checkOutput("wrap_pc", instr_pc, 8'hFF);
    checkOutput("wrap_rom_address", rom_address, 8'h01);

    // Reset while assembling a two-byte instruction
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    checkOutput("mid_rst_valid", {7'b0, instr_valid}, 8'h00);
    checkOutput("mid_rst_rom_address", rom_address, 8'h00);
    checkOutput("mid_rst_opcode", instr_opcode, 8'h00);
    checkOutput("mid_rst_operand", instr_operand, 8'h00);
    checkOutput("mid_rst_pc", instr_pc, 8'h00);
    checkOutput("mid_rst_model_pc", m_pc, 8'h00);

`ifdef BORUSS_FETCH_JMP_FOLD_EN
    // Folded JMP loop: decode only ever sees the SHL at 00
    rom[0] = 8'h60; rom[1] = 8'h80; rom[2] = 8'h00;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (instr_valid) begin
        checkOutput("fold_opcode", instr_opcode, 8'h60);
        checkOutput("fold_pc", instr_pc, 8'h00);
      end
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    tick();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 4))
        0: rom[i] = 8'h01;
        1: rom[i] = boruss_pkg::OP_SHL;
        2: rom[i] = 8'h80 | 8'($urandom_range(0, 31));
        default: rom[i] = 8'($urandom);
      endcase
    end
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0, 8'($urandom));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
